vector_reg_sequencer: RTL and testbench

VECTOR_REG_SEQUENCER -- requirements
Module: vector_reg_sequencer

---
 rtl/vector_reg_sequencer.sv | 93 +++++++++
 tb/tb_vector_reg_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/vector_reg_sequencer.sv
// vector_reg_sequencer: steps one vector instruction through 4-element register groups,
// driving register-file group addresses, the PE start/done handshake and write strobes.
module vector_reg_sequencer #(
    parameter int VL_W = 6
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [VL_W-1:0] vl,
    input  logic [1:0]      vsew,
    input  logic            widening_op,
    input  logic [4:0]      vs1_base,
    input  logic [4:0]      vs2_base,
    input  logic [4:0]      vd_base,
    output logic            pe_start,
    input  logic            pe_done,
    output logic [4:0]      rf_vs1_addr,
    output logic [4:0]      rf_vs2_addr,
    output logic [4:0]      rf_vd_addr,
    output logic [1:0]      rf_vsew,
    output logic            rf_widening_op,
    output logic [1:0]      rf_elements_to_write,
    output logic            rf_write,
    output logic            done,
    output logic            illegal
);
    typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DONE} state_t;
    state_t state, state_nxt;
    logic [VL_W-1:0] vl_q;
    logic [VL_W-3:0] g;
    logic [4:0] vs1_q, vs2_q, vd_q;
    logic illegal_q, accept, bad, last;
    logic [VL_W-1:0] rem;
    logic [4:0] g5;
    logic [2:0] dst_shift;
    assign accept = issue_valid && state == IDLE;
    assign bad = vsew == 2'd3 || (widening_op && vsew == 2'd2);
    // elements still outstanding from the start of the current group
    assign rem = vl_q - {g, 2'b00};
    assign last = rem <= VL_W'(4);
    assign g5 = 5'(g);
    assign dst_shift = {1'b0, rf_vsew} + {2'b00, rf_widening_op};
    assign rf_vs1_addr = vs1_q + (g5 << rf_vsew);
    assign rf_vs2_addr = vs2_q + (g5 << rf_vsew);
    assign rf_vd_addr = vd_q + (g5 << dst_shift);
    assign rf_elements_to_write = rem >= VL_W'(4) ? 2'd0 : rem[1:0];
    assign issue_ready = state == IDLE;
    assign pe_start = state == READ;
    assign rf_write = state == WRITE;
    assign done = state == DONE;
    assign illegal = illegal_q;
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = bad ? IDLE : (vl == '0 ? DONE : READ);
            READ:    state_nxt = EXEC;
            EXEC:    if (pe_done) state_nxt = WRITE;
            WRITE:   state_nxt = last ? DONE : READ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            vl_q <= '0;
            g <= '0;
            vs1_q <= '0;
            vs2_q <= '0;
            vd_q <= '0;
            rf_vsew <= '0;
            rf_widening_op <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && bad;
            if (accept) begin
                vl_q <= vl;
                g <= '0;
                vs1_q <= vs1_base;
                vs2_q <= vs2_base;
                vd_q <= vd_base;
                rf_vsew <= vsew;
                rf_widening_op <= widening_op;
            end else if (state == WRITE && !last) begin
                g <= g + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vector_reg_sequencer.sv
// tb_vector_reg_sequencer: directed and random instructions checked against a
// group-level reference model computed from element counts and register steps.
module tb_vector_reg_sequencer;
    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic issue_valid = 1'b0;
    logic issue_ready;
    logic [5:0] vl = '0;
    logic [1:0] vsew = '0;
    logic widening_op = 1'b0;
    logic [4:0] vs1_base = '0, vs2_base = '0, vd_base = '0;
    logic pe_start;
    logic pe_done = 1'b0;
    logic [4:0] rf_vs1_addr, rf_vs2_addr, rf_vd_addr;
    logic [1:0] rf_vsew, rf_elements_to_write;
    logic rf_widening_op, rf_write, done, illegal;
    int errors = 0;
    int checks = 0;

    vector_reg_sequencer #(.VL_W(6)) dut (
        .clk(clk), .n_reset(n_reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .vl(vl), .vsew(vsew), .widening_op(widening_op),
        .vs1_base(vs1_base), .vs2_base(vs2_base), .vd_base(vd_base),
        .pe_start(pe_start), .pe_done(pe_done),
        .rf_vs1_addr(rf_vs1_addr), .rf_vs2_addr(rf_vs2_addr), .rf_vd_addr(rf_vd_addr),
        .rf_vsew(rf_vsew), .rf_widening_op(rf_widening_op),
        .rf_elements_to_write(rf_elements_to_write), .rf_write(rf_write),
        .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_strobes"}, {pe_start, rf_write, done, illegal}, 0);
        chk({tag, "_addrs"}, {rf_vs1_addr, rf_vs2_addr, rf_vd_addr}, 0);
        chk({tag, "_fields"}, {rf_vsew, rf_widening_op, rf_elements_to_write}, 0);
    endtask

    // Issue one instruction and follow it to completion, comparing each cycle with the model.
    task automatic run(input int l, input int sw, input int w, input int a, input int b,
                       input int d, input int lat);
        int groups, ns, nw, nd, ni, pd_at, wr_at, g, rem;
        bit legal, in_grp, fin;
        legal = !(sw == 3 || (w == 1 && sw == 2));
        groups = (l + 3) / 4;
        @(posedge clk); #1;
        chk("ready_before_accept", issue_ready, 1);
        vl = 6'(l); vsew = 2'(sw); widening_op = 1'(w);
        vs1_base = 5'(a); vs2_base = 5'(b); vd_base = 5'(d);
        issue_valid = 1'b1;
        @(posedge clk); #1;
        // offer junk while busy: it must neither be accepted nor disturb latched fields
        issue_valid = legal;
        vl = 6'($urandom); vsew = 2'($urandom); widening_op = 1'($urandom);
        vs1_base = 5'($urandom); vs2_base = 5'($urandom); vd_base = 5'($urandom);
        ns = 0; nw = 0; nd = 0; ni = 0; pd_at = -1; wr_at = -1; g = 0; in_grp = 0; fin = 0;
        for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
            pe_done = (cyc == pd_at);
            chk("onehot", $countones({pe_start, rf_write, done, illegal}) <= 1, 1);
            if (pe_start) begin
                g = ns; ns++; in_grp = 1; pd_at = cyc + lat;
                if (wr_at > 0) chk("read_after_write", cyc, wr_at + 1);
                pe_done = 1'($urandom_range(0, 1));
            end
            if (in_grp) begin
                rem = l - 4 * g;
                chk("vs1_addr", rf_vs1_addr, (a + g * (1 << sw)) % 32);
                chk("vs2_addr", rf_vs2_addr, (b + g * (1 << sw)) % 32);
                chk("vd_addr", rf_vd_addr, (d + g * (1 << (sw + w))) % 32);
                chk("elems", rf_elements_to_write, rem >= 4 ? 0 : rem);
            end
            if (rf_write) begin
                nw++; in_grp = 0; wr_at = cyc;
                chk("write_group", nw, ns);
                chk("write_time", cyc, pd_at + 1);
                pe_done = 1'($urandom_range(0, 1));
            end
            if (done) begin
                nd++; fin = 1; issue_valid = 1'b0;
                chk("ready_in_done", issue_ready, 0);
                if (l == 0) chk("vl0_latency", cyc, 1);
            end
            if (illegal) begin
                ni++; fin = 1;
                chk("illegal_latency", cyc, 1);
            end
            if (!fin) chk("ready_busy", issue_ready, 0);
            chk("rf_vsew", rf_vsew, sw);
            chk("rf_widening", rf_widening_op, w);
            @(posedge clk); #1;
        end
        issue_valid = 1'b0; pe_done = 1'b0;
        if (!fin) chk("timeout", 0, 1);
        chk("pe_start_count", ns, legal ? groups : 0);
        chk("rf_write_count", nw, legal ? groups : 0);
        chk("done_count", nd, legal ? 1 : 0);
        chk("illegal_count", ni, legal ? 0 : 1);
        chk("ready_after", issue_ready, 1);
        chk("quiet_after", {pe_start, rf_write, done, illegal}, 0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", issue_ready, 1);
        chk_idle_zero("reset");
        n_reset = 1'b1;
        run(10, 0, 0, 4, 8, 12, 2);
        run(6, 2, 0, 8, 20, 16, 2);
        run(8, 1, 1, 4, 10, 16, 1);
        run(5, 2, 1, 1, 2, 3, 1);
        run(7, 3, 0, 1, 2, 3, 1);
        run(0, 1, 0, 5, 6, 7, 1);
        run(32, 2, 0, 30, 29, 28, 3);
        run(4, 0, 1, 31, 31, 31, 1);
        // reset while group 1 is executing
        @(posedge clk); #1;
        vl = 6'd10; vsew = 2'd0; widening_op = 1'b0;
        vs1_base = 5'd4; vs2_base = 5'd8; vd_base = 5'd12;
        issue_valid = 1'b1; pe_done = 1'b1; n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(posedge clk); #1;
            issue_valid = 1'b0;
            if (pe_start) n++;
        end
        pe_done = 1'b0;
        chk("rst_reached_grp1", n, 2);
        chk("rst_grp1_vs1", rf_vs1_addr, 5);
        @(posedge clk); #1;
        chk("rst_exec_hold", {pe_start, rf_write}, 0);
        n_reset = 1'b0;
        #1;
        chk_idle_zero("in_reset");
        pe_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("post_reset_ready", issue_ready, 1);
            chk_idle_zero("post_reset");
        end
        pe_done = 1'b0;
        run(9, 1, 0, 2, 3, 4, 2);
        for (int i = 0; i < 30; i++)
            run($urandom_range(0, 32), $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(1, 4));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
